// File: rtl/svi_array_distributor_if.sv
// Per-channel handshake bundle: producer drives valid/data, consumer drives ready.
interface ch_if #(
   parameter int WIDTH = 8
);
   logic             valid;
   logic [WIDTH-1:0] data;
   logic             ready;

   modport P (output valid, output data, input ready);
   modport C (input valid, input data, output ready);
endinterface

// File: rtl/svi_array_distributor.sv
// Spreads one valid/ready stream over an array of ch_if channels, each backed by
// a one-entry registered slot; target picked round-robin or by fixed priority.
module svi_array_distributor #(
   parameter int N_CH    = 8,
   parameter int WIDTH   = 8,
   parameter int CNT_W   = 16,
   parameter int RR_MODE = 1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_data,
   input  logic [N_CH-1:0]  i_mask,
   ch_if.P                  p [N_CH-1:0],
   output logic [CNT_W-1:0] o_count
);
   localparam int PTR_W = $clog2(N_CH);

   logic [N_CH-1:0]  valid_q;
   logic [WIDTH-1:0] data_q [N_CH];
   logic [N_CH-1:0]  ready;
   logic [N_CH-1:0]  eligible;
   logic [PTR_W-1:0] ptr;
   logic [PTR_W-1:0] base;
   logic [PTR_W-1:0] tgt;
   logic [PTR_W-1:0] ptr_next;
   logic [PTR_W:0]   cand;
   logic             found;
   logic             accept;

   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      assign p[k].valid = valid_q[k];
      assign p[k].data  = data_q[k];
      assign ready[k]   = p[k].ready;
   end

   // A draining slot counts as free, giving one beat per cycle per channel.
   assign eligible = i_mask & (~valid_q | ready);
   assign base     = (RR_MODE != 0) ? ptr : '0;

   always_comb begin
      found = 1'b0;
      tgt   = '0;
      cand  = '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         cand = {1'b0, base} + (PTR_W+1)'(i);
         if (cand >= (PTR_W+1)'(N_CH)) cand = cand - (PTR_W+1)'(N_CH);
         if (!found && eligible[cand[PTR_W-1:0]]) begin
            found = 1'b1;
            tgt   = cand[PTR_W-1:0];
         end
      end
   end

   assign ptr_next = (tgt == PTR_W'(N_CH - 1)) ? '0 : tgt + PTR_W'(1);
   assign o_ready  = found & i_rst_n;
   assign accept   = i_valid & o_ready;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         valid_q <= '0;
         for (int unsigned k = 0; k < N_CH; k++) data_q[k] <= '0;
         ptr     <= '0;
         o_count <= '0;
      end else begin
         for (int unsigned k = 0; k < N_CH; k++) begin
            if (accept && tgt == PTR_W'(k)) begin
               valid_q[k] <= 1'b1;
               data_q[k]  <= i_data;
            end else if (ready[k]) begin
               valid_q[k] <= 1'b0;
            end
         end
         if (accept) begin
            o_count <= o_count + CNT_W'(1);
            if (RR_MODE != 0) ptr <= ptr_next;
         end
      end
   end
endmodule

// File: tb/tb_svi_array_distributor.sv
// Drives a round-robin (4-bit counter) and a fixed-priority distributor with the same
// stimulus and compares both against a queue/array reference model every cycle.
module tb_svi_array_distributor;
   localparam int N = 8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic [7:0] in_data;
   logic [7:0] mask;
   logic [7:0] rdy;

   logic        o_ready0, o_ready1;
   logic [3:0]  o_count0;
   logic [15:0] o_count1;
   logic [7:0]  v0, v1;
   logic [7:0]  d0 [N];
   logic [7:0]  d1 [N];

   ch_if #(.WIDTH(8)) c0 [N-1:0] ();
   ch_if #(.WIDTH(8)) c1 [N-1:0] ();

   for (genvar k = 0; k < N; k++) begin : g_tap
      assign c0[k].ready = rdy[k];
      assign c1[k].ready = rdy[k];
      assign v0[k] = c0[k].valid;
      assign v1[k] = c1[k].valid;
      assign d0[k] = c0[k].data;
      assign d1[k] = c1[k].data;
   end

   svi_array_distributor #(.N_CH(N), .WIDTH(8), .CNT_W(4), .RR_MODE(1)) dut_rr (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(in_valid), .o_ready(o_ready0),
      .i_data(in_data), .i_mask(mask), .p(c0), .o_count(o_count0));

   svi_array_distributor #(.N_CH(N), .WIDTH(8), .CNT_W(16), .RR_MODE(0)) dut_fp (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(in_valid), .o_ready(o_ready1),
      .i_data(in_data), .i_mask(mask), .p(c1), .o_count(o_count1));

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference state: [0] round-robin / 16-wrap, [1] fixed priority / 65536-wrap.
   bit mv [2][N];
   int md [2][N];
   int mptr [2];
   int mcnt [2];
   int cmod [2] = '{16, 65536};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Channel that would receive a beat now, or -1 if none can take one.
   function automatic int pick(int m);
      for (int i = 0; i < N; i++) begin
         int k;
         k = (m == 0) ? (mptr[m] + i) % N : i;
         if (mask[k] && (!mv[m][k] || rdy[k])) return k;
      end
      return -1;
   endfunction

   task automatic model_step();
      for (int m = 0; m < 2; m++) begin
         if (!rst_n) begin
            for (int k = 0; k < N; k++) begin mv[m][k] = 0; md[m][k] = 0; end
            mptr[m] = 0;
            mcnt[m] = 0;
         end else begin
            int t;
            t = pick(m);
            for (int k = 0; k < N; k++) if (rdy[k]) mv[m][k] = 0;
            if (in_valid && t >= 0) begin
               mv[m][t] = 1;
               md[m][t] = int'(in_data);
               mcnt[m]  = (mcnt[m] + 1) % cmod[m];
               if (m == 0) mptr[m] = (t + 1) % N;
            end
         end
      end
   endtask

   task automatic check_all();
      logic [7:0] ev;
      for (int m = 0; m < 2; m++) begin
         ev = '0;
         for (int k = 0; k < N; k++) ev[k] = mv[m][k];
         check($sformatf("ready%0d", m), (m == 0) ? o_ready0 : o_ready1,
               32'((pick(m) >= 0) && rst_n));
         check($sformatf("count%0d", m), (m == 0) ? 32'(o_count0) : 32'(o_count1), 32'(mcnt[m]));
         check($sformatf("valid%0d", m), (m == 0) ? v0 : v1, ev);
         for (int k = 0; k < N; k++)
            if (mv[m][k])
               check($sformatf("data%0d_ch%0d", m, k), (m == 0) ? d0[k] : d1[k], 32'(md[m][k]));
      end
   endtask

   // Called at a negedge with inputs set; returns at the following negedge.
   task automatic step();
      #1;
      check_all();
      model_step();
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b1; in_data = '0; mask = 8'hFF; rdy = 8'hFF;
      for (int m = 0; m < 2; m++) begin
         mptr[m] = 0; mcnt[m] = 0;
         for (int k = 0; k < N; k++) begin mv[m][k] = 0; md[m][k] = 0; end
      end
      @(negedge clk);

      step(); step();
      #1;
      check("rst_ready", o_ready0, 0);
      check("rst_valid", v0, 0);
      check("rst_count", 32'(o_count0), 0);

      rst_n = 1'b1; in_data = 8'hA5;
      step();
      in_valid = 1'b0;
      check("a5_rr_ch0", {v0[0], d0[0]}, {1'b1, 8'hA5});
      check("a5_fp_ch0", {v1[0], d1[0]}, {1'b1, 8'hA5});

      // Round-robin sweep of 0..9
      rst_n = 1'b0; step();
      rst_n = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin in_data = 8'(i); step(); end
      in_valid = 1'b0;
      check("sweep_count", 32'(o_count0), 10);
      check("sweep_ch1", {v0[1], d0[1]}, {1'b1, 8'h09});
      check("sweep_fp_ch0", {v1[0], d1[0]}, {1'b1, 8'h09});

      // Channel 2 stalled: its beat must hold while others keep flowing
      rdy = 8'hFB; in_valid = 1'b1; in_data = 8'h20;
      step();
      for (int i = 0; i < 10; i++) begin
         in_data = 8'(8'h40 + i);
         step();
         check("hold_ch2", {v0[2], d0[2]}, {1'b1, 8'h20});
      end
      rdy = 8'hFF; in_valid = 1'b0;
      step(); step();

      // Mask 0x05, then all masked
      mask = 8'h05; in_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin in_data = 8'(8'h60 + i); step(); end
      mask = 8'h00;
      #1;
      check("mask0_ready", o_ready0, 0);
      step(); step();

      // Fixed priority with ch0 blocked
      mask = 8'hFF; rdy = 8'hFE;
      for (int i = 0; i < 5; i++) begin in_data = 8'(8'h80 + i); step(); end
      rdy = 8'hFF;

      // 4-bit counter wrap after 17 accepts
      rst_n = 1'b0; step();
      rst_n = 1'b1;
      for (int i = 0; i < 17; i++) begin in_data = 8'(i); step(); end
      in_valid = 1'b0;
      check("wrap_count", 32'(o_count0), 1);

      // Random traffic with occasional mid-run reset
      for (int i = 0; i < 1500; i++) begin
         rst_n    = ($urandom_range(0, 49) != 0);
         in_valid = ($urandom_range(0, 4) != 0);
         in_data  = 8'($urandom);
         mask     = ($urandom_range(0, 3) != 0) ? 8'hFF : 8'($urandom);
         rdy      = 8'($urandom) | 8'($urandom);
         step();
      end
      rst_n = 1'b1; in_valid = 1'b0;
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete, expected finish");
      $fatal(1);
   end
endmodule

// File: doc/svi_array_distributor.md
Name: svi_array_distributor

Overview:
- Distributes a single valid/ready input stream across an array of N_CH SystemVerilog interface (SVI) channels.
- Each channel has a one-entry registered output slot. Channels are picked by round-robin or fixed priority, and a per-channel enable mask can exclude channels.
- Sits between a producer and N_CH consumers, generalising the always_ff-driven SVI array to parametrised channel count, width and handshaking.

Parameters:
- N_CH, 8, number of output channels (2..32); interface array is p[N_CH-1:0].
- WIDTH, 8, payload width; also the parameter of interface ch_if.
- CNT_W, 16, width of the accepted-beat counter.
- RR_MODE, 1, 1 = round-robin selection, 0 = fixed priority (lowest index first).

Ports:
- i_clk  input  1  clock; all state updates on posedge.
- i_rst_n  input  1  reset, synchronous, active-low.
- i_valid  input  1  input beat valid.
- o_ready  output  1  input beat accepted this cycle when i_valid & o_ready.
- i_data  input  WIDTH  input payload.
- i_mask  input  N_CH  channel enable; bit k=1 makes channel k eligible for new beats.
- p  ch_if.P array  [N_CH-1:0]  per channel: output valid (1), output data (WIDTH), input ready (1).
- o_count  output  CNT_W  total accepted input beats; wraps modulo 2^CNT_W.

Behaviour:
- Clocking and reset: one clock, i_clk. Reset is synchronous and active-low on i_rst_n.
- Reset values while i_rst_n=0 at a posedge:
  - all p[k].valid=0 and p[k].data=0;
  - pointer ptr=0;
  - o_count=0.
  - o_ready is forced to 0 while i_rst_n=0.
- Reset mid-operation: all buffered slot contents are discarded with no drain.
- Slot k state is {valid_k, data_k}. p[k].valid and p[k].data are driven directly from these registers, with no combinational path from i_data.
- Drain: slot k drains when valid_k & p[k].ready at the posedge. It then clears, unless it is reloaded in the same cycle.
- Accept condition: slot k can accept when eligible_k = i_mask[k] & (~valid_k | p[k].ready).
  - A draining slot can accept a new beat in the same cycle (full throughput per channel).
- Target selection (combinational):
  - RR_MODE=1: first k with eligible_k, searching cyclically from ptr (ptr, ptr+1, ..., N_CH-1, 0, ..., ptr-1).
  - RR_MODE=0: lowest k with eligible_k; ptr is unused and held at 0.
- o_ready = (any eligible_k) & i_rst_n. The combinational path from p[k].ready and i_mask to o_ready is permitted.
- On accept (i_valid & o_ready), at the posedge:
  - valid_t <= 1 and data_t <= i_data for target t;
  - o_count <= o_count+1;
  - RR_MODE=1 only: ptr <= (t+1) mod N_CH, with wrap from N_CH-1 to 0.
- If no beat is accepted, ptr holds.
- Exactly one slot is loaded per accepted beat; beats are never duplicated or dropped after acceptance.
- Masking:
  - Clearing i_mask[k] stops new loads into slot k only. Existing contents still present with valid=1 and drain normally.
  - i_mask all zero gives o_ready=0.
- Held slot: p[k].valid, once 1, stays 1 with data stable until p[k].ready=1.
- Latency: an input beat appears on p[t] one cycle after acceptance.
- Counter: o_count wraps from 2^CNT_W-1 to 0 with no saturation.
- Simultaneous events: reset has priority over accept and drain.

Test Plan:
- Reset: hold i_rst_n=0 for 2 cycles with i_valid=1 -> o_ready=0, all p[k].valid=0, o_count=0; after release with all ready=1 and i_mask='1, first beat 0xA5 appears on p[0] next cycle.
- Round-robin sweep, RR_MODE=1, N_CH=8, all ready=1, mask=0xFF: stream data 0..9 -> data 0..7 land on channels 0..7, 8 on ch0, 9 on ch1; o_count=10.
- Backpressure/skip: p[2].ready=0 with slot 2 full, mask=0xFF, ptr=2 -> next beat goes to ch3; ch2 holds data stable until ready rises, then drains.
- Mask: mask=0x05 with continuous valid -> beats alternate ch0, ch2 only; mask=0x00 -> o_ready=0 and o_count unchanged.
- Fixed priority, RR_MODE=0: all ready=1 -> every beat goes to ch0; ch0 ready=0 and full -> beats go to ch1.
- Wrap and mid-run reset: CNT_W=4, 17 accepts -> o_count=1; assert i_rst_n=0 with 3 slots full -> next cycle all valid=0, ptr=0.
